// File: rtl/mips_mem_arbiter.sv
// Data-memory port arbiter: CPU has priority, one accelerator shares the port via req/gnt.
// Define ARB_PERF_CNT_EN to build the stall/beat performance counters (otherwise tied to 0).
module mips_mem_arbiter #(
   parameter int MAX_WAIT  = 8,
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_in,
   output logic        cpu_en,
   input  logic [3:0]  cpu_mem_write_en,
   input  logic        cpu_mem_read_en,
   input  logic [31:0] cpu_mem_addr,
   input  logic [31:0] cpu_mem_write_data,
   output logic [31:0] cpu_mem_read_data,
   input  logic        acc_req,
   input  logic [3:0]  acc_we,
   input  logic [31:0] acc_addr,
   input  logic [31:0] acc_wdata,
   output logic        acc_gnt,
   output logic        acc_rvalid,
   output logic [31:0] acc_rdata,
   output logic [3:0]  mem_write_en,
   output logic        mem_read_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   output logic [31:0] perf_cpu_stall,
   output logic [31:0] perf_acc_beats,
   output logic        dbg_state
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {S_CPU = 1'b0, S_ACC = 1'b1} state_t;

   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic [BW-1:0] burst_cnt;
   logic          yield;
   logic          cpu_rd_pend;
   logic          acc_rd_pend;
   logic [31:0]   rd_hold;

   logic cpu_access;
   logic wait_full;
   logic burst_last;
   logic acc_rd_beat;
   logic go_acc;
   logic go_cpu;

   // Handshake: a beat transfers in any cycle with acc_req=1 and acc_gnt=1; acc_gnt is never
   // raised without acc_req, and the requester holds acc_addr/acc_we/acc_wdata until granted.
   always_comb begin
      cpu_access     = (|cpu_mem_write_en) | cpu_mem_read_en;
      wait_full      = (wait_cnt == WW'(MAX_WAIT));
      burst_last     = (burst_cnt == BW'(MAX_BURST - 1));
      cpu_en         = 1'b0;
      acc_gnt        = 1'b0;
      mem_write_en   = 4'b0;
      mem_read_en    = 1'b0;
      mem_addr       = cpu_mem_addr;
      mem_write_data = cpu_mem_write_data;
      case (state)
         S_CPU: begin
            cpu_en         = en_in;
            mem_write_en   = en_in ? cpu_mem_write_en : 4'b0;
            mem_read_en    = en_in & cpu_mem_read_en;
            mem_addr       = cpu_mem_addr;
            mem_write_data = cpu_mem_write_data;
         end
         S_ACC: begin
            acc_gnt        = acc_req & en_in;
            mem_write_en   = acc_gnt ? acc_we : 4'b0;
            mem_read_en    = acc_gnt & (acc_we == 4'b0);
            mem_addr       = acc_addr;
            mem_write_data = acc_wdata;
         end
         default: ;
      endcase
      acc_rd_beat = acc_gnt & (acc_we == 4'b0);
      go_acc = (state == S_CPU) & en_in & acc_req & ~yield & (~cpu_access | wait_full);
      go_cpu = (state == S_ACC) & en_in & (~acc_req | (acc_gnt & burst_last));
   end

   // A frozen CPU keeps seeing its returned word via rd_hold after the SRAM output moves on.
   assign cpu_mem_read_data = cpu_rd_pend ? mem_read_data : rd_hold;
   assign acc_rvalid        = acc_rd_pend;
   assign acc_rdata         = mem_read_data;
   assign dbg_state         = (state == S_ACC);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_CPU;
         wait_cnt    <= '0;
         burst_cnt   <= '0;
         yield       <= 1'b0;
         cpu_rd_pend <= 1'b0;
         acc_rd_pend <= 1'b0;
         rd_hold     <= '0;
      end else begin
         cpu_rd_pend <= (state == S_CPU) & en_in & cpu_mem_read_en;
         acc_rd_pend <= acc_rd_beat;
         if (cpu_rd_pend)
            rd_hold <= mem_read_data;
         if (en_in) begin
            yield <= (state == S_ACC) & acc_gnt & burst_last;
            case (state)
               S_CPU: begin
                  if (go_acc) begin
                     state    <= S_ACC;
                     wait_cnt <= '0;
                  end else if (!acc_req) begin
                     wait_cnt <= '0;
                  end else if (!wait_full) begin
                     wait_cnt <= wait_cnt + WW'(1);
                  end
               end
               S_ACC: begin
                  if (!acc_req)
                     wait_cnt <= '0;
                  if (go_cpu) begin
                     state     <= S_CPU;
                     burst_cnt <= '0;
                  end else if (acc_gnt) begin
                     burst_cnt <= burst_cnt + BW'(1);
                  end
               end
               default: state <= S_CPU;
            endcase
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] stall_q;
   logic [31:0] beats_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
         beats_q <= '0;
      end else begin
         if ((state == S_ACC) && en_in)
            stall_q <= stall_q + 32'd1;
         if (acc_gnt)
            beats_q <= beats_q + 32'd1;
      end
   end

   assign perf_cpu_stall = stall_q;
   assign perf_acc_beats = beats_q;
`else
   assign perf_cpu_stall = '0;
   assign perf_acc_beats = '0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: SRAM model, per-cycle reference model, literal spot checks.
module tb_mips_mem_arbiter;

   localparam int MAX_WAIT  = 8;
   localparam int MAX_BURST = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en_in = 1'b1;
   logic        cpu_en;
   logic [3:0]  cpu_mem_write_en = 4'b0;
   logic        cpu_mem_read_en = 1'b0;
   logic [31:0] cpu_mem_addr = '0;
   logic [31:0] cpu_mem_write_data = '0;
   logic [31:0] cpu_mem_read_data;
   logic        acc_req = 1'b0;
   logic [3:0]  acc_we = 4'b0;
   logic [31:0] acc_addr = '0;
   logic [31:0] acc_wdata = '0;
   logic        acc_gnt;
   logic        acc_rvalid;
   logic [31:0] acc_rdata;
   logic [3:0]  mem_write_en;
   logic        mem_read_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data = '0;
   logic [31:0] perf_cpu_stall;
   logic [31:0] perf_acc_beats;
   logic        dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   mips_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst), .en_in(en_in), .cpu_en(cpu_en),
      .cpu_mem_write_en(cpu_mem_write_en), .cpu_mem_read_en(cpu_mem_read_en),
      .cpu_mem_addr(cpu_mem_addr), .cpu_mem_write_data(cpu_mem_write_data),
      .cpu_mem_read_data(cpu_mem_read_data),
      .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
      .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
      .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .perf_cpu_stall(perf_cpu_stall), .perf_acc_beats(perf_acc_beats),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- SRAM: synchronous, 1-cycle read latency, byte writes ----------------
   function automatic logic [31:0] init_word(input int i);
      case (i)
         64:      return 32'hDEADBEEF;  // 0x100
         128:     return 32'h11112222;  // 0x200
         129:     return 32'h33334444;  // 0x204
         130:     return 32'h55556666;  // 0x208
         192:     return 32'hC0FFEE00;  // 0x300
         default: return {16'h5A5A, 16'(i)};
      endcase
   endfunction

   logic [31:0] sram [0:255];

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
      end else begin
         if (mem_read_en) mem_read_data <= sram[mem_addr[9:2]];
         for (int b = 0; b < 4; b++)
            if (mem_write_en[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
      end
   end

   // ---------------- reference model, checked every cycle ----------------
   bit          m_acc_owns;
   int          m_waited;
   int          m_beats_in_grant;
   bit          m_yield;
   logic [31:0] m_hold;
   logic [31:0] exp_q[$];
   logic [31:0] cpu_q[$];
   int          m_stall;
   int          m_beats;
   logic [31:0] acc_rd_log[$];

   always @(negedge clk) begin : model
      logic        access, gnt, erd, ecpu_en, evalid;
      logic [3:0]  ewe;
      logic [31:0] eaddr, ewdata, ecpu, eacc;
      if (!rst) begin
         m_acc_owns = 0; m_waited = 0; m_beats_in_grant = 0; m_yield = 0; m_hold = '0;
         exp_q.delete(); cpu_q.delete(); m_stall = 0; m_beats = 0;
         chkb("rst_cpu_en", cpu_en, en_in);
         chkb("rst_acc_gnt", acc_gnt, 1'b0);
         chkb("rst_rvalid", acc_rvalid, 1'b0);
         chk("rst_cpu_rdata", cpu_mem_read_data, 32'h0);
         chkb("rst_state", dbg_state, 1'b0);
      end else begin
         access = (cpu_mem_write_en != 4'b0) || cpu_mem_read_en;
         if (!m_acc_owns) begin
            ecpu_en = en_in; gnt = 1'b0;
            erd = en_in && cpu_mem_read_en; ewe = en_in ? cpu_mem_write_en : 4'b0;
            eaddr = cpu_mem_addr; ewdata = cpu_mem_write_data;
         end else begin
            ecpu_en = 1'b0; gnt = acc_req && en_in;
            erd = gnt && (acc_we == 4'b0); ewe = gnt ? acc_we : 4'b0;
            eaddr = acc_addr; ewdata = acc_wdata;
         end
         ecpu = m_hold;
         if (cpu_q.size() > 0) begin
            ecpu = cpu_q.pop_front();
            m_hold = ecpu;
         end
         evalid = (exp_q.size() > 0);

         chkb("cpu_en", cpu_en, ecpu_en);
         chkb("acc_gnt", acc_gnt, gnt);
         chkb("mem_read_en", mem_read_en, erd);
         chk("mem_write_en", 32'(mem_write_en), 32'(ewe));
         if (erd || ewe != 4'b0) chk("mem_addr", mem_addr, eaddr);
         if (ewe != 4'b0) chk("mem_write_data", mem_write_data, ewdata);
         chk("cpu_rdata", cpu_mem_read_data, ecpu);
         chkb("acc_rvalid", acc_rvalid, evalid);
         chkb("state", dbg_state, m_acc_owns);
         if (evalid) begin
            eacc = exp_q.pop_front();
            chk("acc_rdata", acc_rdata, eacc);
         end
`ifdef ARB_PERF_CNT_EN
         chk("perf_stall", perf_cpu_stall, 32'(m_stall));
         chk("perf_beats", perf_acc_beats, 32'(m_beats));
`else
         chk("perf_stall_tied", perf_cpu_stall, 32'h0);
         chk("perf_beats_tied", perf_acc_beats, 32'h0);
`endif
         if (acc_rvalid) acc_rd_log.push_back(acc_rdata);
         if (erd && !m_acc_owns) cpu_q.push_back(sram[cpu_mem_addr[9:2]]);
         if (erd && m_acc_owns) exp_q.push_back(sram[acc_addr[9:2]]);
         if (m_acc_owns && en_in) m_stall++;
         if (gnt) m_beats++;

         if (en_in) begin
            if (!m_acc_owns) begin
               if (acc_req && !m_yield && (!access || m_waited == MAX_WAIT)) begin
                  m_acc_owns = 1; m_waited = 0;
               end else if (!acc_req) begin
                  m_waited = 0;
               end else if (m_waited < MAX_WAIT) begin
                  m_waited++;
               end
               m_yield = 0;
            end else begin
               if (!acc_req) begin
                  m_acc_owns = 0; m_beats_in_grant = 0; m_yield = 0;
               end else if (gnt && m_beats_in_grant == MAX_BURST - 1) begin
                  m_acc_owns = 0; m_beats_in_grant = 0; m_yield = 1;
               end else begin
                  if (gnt) m_beats_in_grant++;
                  m_yield = 0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds acc_req for nbeats accepted beats; reports first/last grant cycle relative to start.
   task automatic run_acc(input int nbeats, input logic [31:0] base, input logic [3:0] we,
                          input bit chk_cpu, input logic [31:0] cpu_lit,
                          output int first, output int last);
      int  beats;
      int  c;
      bit  g;
      beats = 0; c = 0; first = -1; last = -1;
      acc_req = 1'b1; acc_addr = base; acc_we = we; acc_wdata = 32'hBEEF0000;
      while (beats < nbeats && c < 100) begin
         @(negedge clk);
         g = acc_gnt;
         if (g) begin
            if (first < 0) first = c;
            last = c;
            beats++;
            if (chk_cpu) chk("frozen_cpu_rdata", cpu_mem_read_data, cpu_lit);
         end
         tick();
         if (g) begin
            acc_addr = acc_addr + 32'd4;
            acc_wdata = acc_wdata + 32'd1;
         end
         if (beats == nbeats) acc_req = 1'b0;
         c++;
      end
      if (beats < nbeats) begin
         n_cmp++; n_err++;
         $display("FAIL acc_timeout: got %0d beats want %0d", beats, nbeats);
         acc_req = 1'b0;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int first, last;
      @(negedge clk);
      chkb("reset_gnt", acc_gnt, 1'b0);
      chk("reset_rdata", cpu_mem_read_data, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // CPU load with the accelerator idle
      cpu_mem_read_en = 1'b1; cpu_mem_addr = 32'h100;
      @(negedge clk);
      chkb("lw_issue", mem_read_en, 1'b1);
      tick();
      cpu_mem_read_en = 1'b0;
      @(negedge clk);
      chk("lw_data", cpu_mem_read_data, 32'hDEADBEEF);
      chkb("lw_cpu_en", cpu_en, 1'b1);
      tick();

      // partial store then load back
      cpu_mem_write_en = 4'b0011; cpu_mem_addr = 32'h100; cpu_mem_write_data = 32'h12345678;
      tick();
      cpu_mem_write_en = 4'b0; cpu_mem_read_en = 1'b1;
      tick();
      cpu_mem_read_en = 1'b0;
      @(negedge clk);
      chk("sw_byte_data", cpu_mem_read_data, 32'hDEAD5678);
      tick();

      // three accelerator reads, CPU idle
      acc_rd_log.delete();
      run_acc(3, 32'h200, 4'b0, 1'b0, 32'h0, first, last);
      chk("t2_first", 32'(first), 32'd1);
      chk("t2_last", 32'(last), 32'd3);
      @(negedge clk);
      chkb("t2_still_acc", dbg_state, 1'b1);
      tick();
      @(negedge clk);
      chkb("t2_back_cpu", cpu_en, 1'b1);
      chk("t2_nreads", 32'(acc_rd_log.size()), 32'd3);
      if (acc_rd_log.size() == 3) begin
         chk("t2_rd0", acc_rd_log[0], 32'h11112222);
         chk("t2_rd1", acc_rd_log[1], 32'h33334444);
         chk("t2_rd2", acc_rd_log[2], 32'h55556666);
      end
      tick();

      // CPU busy every cycle: forced grant after MAX_WAIT, CPU read data held while frozen
      cpu_mem_read_en = 1'b1; cpu_mem_addr = 32'h300;
      run_acc(3, 32'h20C, 4'b0, 1'b1, 32'hC0FFEE00, first, last);
      chk("t3_first", 32'(first), 32'd9);
      chk("t3_last", 32'(last), 32'd11);
      @(negedge clk);
      chk("t3_hold", cpu_mem_read_data, 32'hC0FFEE00);
      chkb("t3_frozen", cpu_en, 1'b0);
      tick();
      @(negedge clk);
      chkb("t3_resume", cpu_en, 1'b1);
      tick();
      cpu_mem_read_en = 1'b0;
      tick();

      // ten write beats split by the burst limit
      run_acc(10, 32'h240, 4'hF, 1'b0, 32'h0, first, last);
      chk("t4_first", 32'(first), 32'd1);
      chk("t4_last", 32'(last), 32'd14);
`ifdef ARB_PERF_CNT_EN
      chk("t4_perf_beats", perf_acc_beats, 32'd16);
`endif
      tick();
      tick();
      cpu_mem_read_en = 1'b1; cpu_mem_addr = 32'h248;
      tick();
      cpu_mem_read_en = 1'b0;
      @(negedge clk);
      chk("t4_readback", cpu_mem_read_data, 32'hBEEF0002);
      tick();

      // en_in low during a grant: hold, no new beat, pending read still retires
      acc_req = 1'b1; acc_addr = 32'h200; acc_we = 4'b0;
      @(negedge clk);
      chkb("en_c0_gnt", acc_gnt, 1'b0);
      tick();
      @(negedge clk);
      chkb("en_c1_gnt", acc_gnt, 1'b1);
      tick();
      en_in = 1'b0;
      @(negedge clk);
      chkb("en_off_gnt", acc_gnt, 1'b0);
      chkb("en_off_rvalid", acc_rvalid, 1'b1);
      chk("en_off_rdata", acc_rdata, 32'h11112222);
      chkb("en_off_mre", mem_read_en, 1'b0);
      tick();
      en_in = 1'b1;
      @(negedge clk);
      chkb("en_on_gnt", acc_gnt, 1'b1);
      tick();
      acc_req = 1'b0;
      tick();
      tick();

      // en_in low in CPU state blocks the CPU access
      en_in = 1'b0; cpu_mem_read_en = 1'b1; cpu_mem_addr = 32'h104;
      @(negedge clk);
      chkb("en_off_cpu_mre", mem_read_en, 1'b0);
      chkb("en_off_cpu_en", cpu_en, 1'b0);
      tick();
      en_in = 1'b1; cpu_mem_read_en = 1'b0;
      tick();

      // asynchronous reset during the second beat
      acc_req = 1'b1; acc_addr = 32'h200; acc_we = 4'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      chkb("rb_beat1", acc_gnt, 1'b1);
      tick();
      acc_addr = 32'h204;
      @(negedge clk);
      chkb("rb_beat2", acc_gnt, 1'b1);
      #2 rst = 1'b0;
      #1;
      chkb("rb_async_gnt", acc_gnt, 1'b0);
      chkb("rb_async_rvalid", acc_rvalid, 1'b0);
      chkb("rb_async_cpu_en", cpu_en, 1'b1);
      chkb("rb_async_state", dbg_state, 1'b0);
      chk("rb_async_rdata", cpu_mem_read_data, 32'h0);
      acc_req = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      chkb("rb_after_cpu_en", cpu_en, 1'b1);
      chkb("rb_after_state", dbg_state, 1'b0);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
